seq_borrow_skip_sub_32: RTL and testbench

Multi-cycle 32-bit subtractor computing diff = a − b − bin, one 4-bit slice per clock, with borrow-skip logic inside each slice. It is the subtract counterpart to the team's 32-bit carry-skip adder and sits beside it in the arithmetic library. It gives datapaths a compact, registered subtract unit with a start/done handshake and status flags.

---
 rtl/seq_borrow_skip_sub_32.sv | 141 ++++++++++++++
 tb/tb_seq_borrow_skip_sub_32.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_borrow_skip_sub_32.sv
// Multi-cycle 32-bit subtractor: diff = a - b - bin, one 4-bit borrow-skip slice per clock.
module seq_borrow_skip_sub_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] diff,
    output logic        bout,
    output logic        zero,
    output logic        ovf
);

    localparam int unsigned W       = 32;
    localparam int unsigned SW      = 4;
    localparam int unsigned KW      = 3;
    localparam logic [KW-1:0] K_LAST = KW'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [KW-1:0]  r_k;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_borrow;
    logic [W-1:0]   r_wdiff;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_diff;
    logic           r_bout;
    logic           r_zero;
    logic           r_ovf;

    logic [SW-1:0]  w_sa;
    logic [SW-1:0]  w_sb;
    logic [SW-1:0]  w_sd;
    logic [SW:0]    w_chain;
    logic           w_p;
    logic           w_slice_bout;
    logic [W-1:0]   w_wdiff_nxt;
    logic [4:0]     w_base;

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;
    assign ovf  = r_ovf;

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_k == K_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Current slice: ripple borrow chain plus skip path when every bit propagates
    always_comb begin
        w_base     = {r_k, 2'b00};
        w_sa       = r_a[w_base +: SW];
        w_sb       = r_b[w_base +: SW];
        w_sd       = '0;
        w_p        = 1'b1;
        w_chain    = '0;
        w_chain[0] = r_borrow;
        for (int i = 0; i < SW; i++) begin
            w_sd[i]      = w_sa[i] ^ w_sb[i] ^ w_chain[i];
            w_chain[i+1] = (~w_sa[i] & w_sb[i]) | (~(w_sa[i] ^ w_sb[i]) & w_chain[i]);
            w_p          = w_p & ~(w_sa[i] ^ w_sb[i]);
        end
        w_slice_bout = w_p ? r_borrow : w_chain[SW];
        w_wdiff_nxt  = r_wdiff;
        w_wdiff_nxt[w_base +: SW] = w_sd;
    end

    // Operand capture, slice stepping and atomic result load on the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_wdiff  <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_k      <= '0;
                        r_wdiff  <= '0;
                    end
                end
                S_RUN: begin
                    r_wdiff  <= w_wdiff_nxt;
                    r_borrow <= w_slice_bout;
                    if (r_k != K_LAST) begin
                        r_k <= r_k + KW'(1);
                    end else begin
                        r_diff <= w_wdiff_nxt;
                        r_bout <= w_slice_bout;
                        r_zero <= (w_wdiff_nxt == '0);
                        r_ovf  <= (r_a[W-1] != r_b[W-1]) && (w_wdiff_nxt[W-1] != r_a[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_borrow_skip_sub_32.sv
// Directed and random bench for seq_borrow_skip_sub_32.
module tb_seq_borrow_skip_sub_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_diff;
    logic        last_bout;
    logic        last_zero;
    logic        last_ovf;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vt [7];

    seq_borrow_skip_sub_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One operation: accept, scramble inputs, wait for done, check latency/stability/handshake
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic tbin,
                          input bit mid_start,
                          output logic [31:0] od, output logic ob, output logic oz, output logic oo);
        int n;
        bit stable;
        @(negedge clk);
        start = 1'b1; a = ta; b = tbv; bin = tbin;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
        check("busy_after_accept", 64'(busy), 64'(1));
        n = 0;
        stable = 1'b1;
        while (!done && n < 20) begin
            if (diff !== last_diff || bout !== last_bout || zero !== last_zero || ovf !== last_ovf)
                stable = 1'b0;
            if (!busy) stable = 1'b0;
            if (mid_start && n == 2) begin
                start = 1'b1; a = 32'h0F0F_0F0F; b = 32'h7070_7070; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("stable_during_run", 64'(stable), 64'(1));
        check("done_latency", 64'(n), 64'(8));
        od = diff; ob = bout; oz = zero; oo = ovf;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    task automatic check_result(input string tag, input logic [31:0] od, input logic ob,
                                input logic oz, input logic oo,
                                input logic [31:0] ed, input logic eb, input logic ez, input logic eo);
        check({tag, "_diff"}, 64'(od), 64'(ed));
        check({tag, "_bout"}, 64'(ob), 64'(eb));
        check({tag, "_zero"}, 64'(oz), 64'(ez));
        check({tag, "_ovf"},  64'(oo), 64'(eo));
        last_diff = ed; last_bout = eb; last_zero = ez; last_ovf = eo;
    endtask

    initial begin
        logic [31:0] od;
        logic        ob, oz, oo;
        logic [32:0] m;
        logic [31:0] ra, rb;
        logic        rbin;
        int          ndone;
        int          t_first, t_second;

        vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vt[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vt[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_diff = '0; last_bout = 1'b0; last_zero = 1'b0; last_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_flags", 64'({bout, zero, ovf}), 64'(0));
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].bin, 1'b0, od, ob, oz, oo);
            check_result($sformatf("vec%0d", i), od, ob, oz, oo, vt[i].d, vt[i].bo, vt[i].z, vt[i].o);
        end

        // start pulsed in RUN cycle 3 is ignored; exactly one done
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, od, ob, oz, oo);
        check_result("ignore_start", od, ob, oz, oo, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore_start_no_extra_done", 64'(ndone), 64'(0));
        check("ignore_start_idle", 64'(busy), 64'(0));

        // start held high: back-to-back operations, done pulses 10 cycles apart
        @(negedge clk);
        start = 1'b1; a = 32'h0000_0010; b = 32'h0000_0001; bin = 1'b0;
        t_first = -1; t_second = -1;
        for (int i = 0; i < 40 && t_second < 0; i++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_diff", 64'(diff), 64'(32'h0000_000F));
                if (t_first < 0) t_first = i;
                else begin
                    t_second = i;
                    start = 1'b0;
                end
            end
        end
        check("b2b_spacing", 64'(t_second - t_first), 64'(10));
        repeat (2) @(negedge clk);
        check("b2b_idle", 64'(busy), 64'(0));
        last_diff = 32'h0000_000F; last_bout = 1'b0; last_zero = 1'b0; last_ovf = 1'b0;

        // Reset in RUN with k=4: async clear, no done
        @(negedge clk);
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_1111; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_diff", 64'(diff), 64'(0));
        check("midrst_flags", 64'({bout, zero, ovf}), 64'(0));
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'(0));
        last_diff = '0; last_bout = 1'b0; last_zero = 1'b0; last_ovf = 1'b0;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, od, ob, oz, oo);
        check_result("after_rst", od, ob, oz, oo, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Random operands against a 33-bit reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
            if (i % 50 == 0) rb = ra;
            m = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
            run_op(ra, rb, rbin, 1'b0, od, ob, oz, oo);
            check_result("rand", od, ob, oz, oo, m[31:0], m[32], (m[31:0] == 32'd0),
                         (ra[31] != rb[31]) && (m[31] != ra[31]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
